// File: rtl/cam_pkg.sv
// Shared state encoding, quarter-phase and bus-operation codes for the camera init sequencer.
package cam_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_PWR, S_BOOT, S_FETCH, S_START, S_BYTE, S_STOP, S_GAP, S_FIN
  } state_t;

  localparam logic [15:0] TBL_END      = 16'hFFFF;
  localparam logic [7:0]  DEV_ADDR_DEF = 8'h42;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic [1:0] K_START = 2'd0;
  localparam logic [1:0] K_BYTE  = 2'd1;
  localparam logic [1:0] K_STOP  = 2'd2;
endpackage

// File: rtl/sccb_byte_tx.sv
// SCCB START/BYTE/STOP engine with quarter-bit divider; one op per go, rdy high when idle.
// Op takes 4 quarters (START/STOP) or 36 quarters (BYTE); go is only accepted while rdy.
module sccb_byte_tx
  import cam_pkg::*;
#(
  parameter int CLK_HZ  = 48000000,
  parameter int SCCB_HZ = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [1:0] kind,
  input  logic [7:0] byte_dat,
  input  logic       sda_in,
  output logic       rdy,
  output logic       nak,
  output logic       scl_oe,
  output logic       sda_oe
);
  // DIV must come out >= 1 for the chosen clock and bus rates.
  localparam int          DIV    = CLK_HZ / (4 * SCCB_HZ);
  localparam logic [31:0] DIV_M1 = 32'(DIV - 1);

  logic        active;
  logic [31:0] qcnt;
  logic [1:0]  qph;
  logic [3:0]  bitn;
  logic [7:0]  sh;
  logic [1:0]  kind_q;
  logic        tick;

  assign tick = (qcnt == DIV_M1);
  assign rdy  = ~active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      qcnt   <= '0;
      qph    <= Q0;
      bitn   <= '0;
      sh     <= '0;
      kind_q <= K_START;
      nak    <= 1'b0;
      scl_oe <= 1'b0;
      sda_oe <= 1'b0;
    end else if (!active) begin
      if (go) begin
        active <= 1'b1;
        qcnt   <= '0;
        qph    <= Q0;
        bitn   <= '0;
        sh     <= byte_dat;
        kind_q <= kind;
      end
    end else begin
      qcnt <= tick ? '0 : qcnt + 32'd1;
      if (tick) begin
        qph <= qph + 2'd1;
        case (kind_q)
          K_START: begin
            case (qph)
              Q0: begin scl_oe <= 1'b0; sda_oe <= 1'b0; end
              Q1: sda_oe <= 1'b1;
              Q3: begin scl_oe <= 1'b1; active <= 1'b0; end
              default: ;
            endcase
          end
          K_BYTE: begin
            case (qph)
              // Ninth bit: release SDA so the slave can answer.
              Q0: begin scl_oe <= 1'b1; sda_oe <= (bitn == 4'd8) ? 1'b0 : ~sh[7]; end
              Q1: scl_oe <= 1'b0;
              Q2: if (bitn == 4'd8) nak <= sda_in;
              Q3: begin
                scl_oe <= 1'b1;
                if (bitn == 4'd8) begin
                  active <= 1'b0;
                end else begin
                  bitn <= bitn + 4'd1;
                  sh   <= {sh[6:0], 1'b0};
                end
              end
              default: ;
            endcase
          end
          K_STOP: begin
            case (qph)
              Q0: sda_oe <= 1'b1;
              Q1: scl_oe <= 1'b0;
              Q3: begin sda_oe <= 1'b0; active <= 1'b0; end
              default: ;
            endcase
          end
          default: active <= 1'b0;
        endcase
      end
    end
  end
endmodule

// File: rtl/cam_sccb_init.sv
// Camera power/reset/boot sequencer that writes an external (reg,val) table over SCCB; start ignored while busy.
// Optional NAK abort (sets err, STOP, finish with done=0) when SCCB_ACK_CHECK_EN is defined.
module cam_sccb_init
  import cam_pkg::*;
#(
  parameter int          CLK_HZ       = 48000000,
  parameter int          SCCB_HZ      = 100000,
  parameter logic [7:0]  DEV_ADDR     = DEV_ADDR_DEF,
  parameter int          RESET_CYCLES = 48000,
  parameter int          BOOT_CYCLES  = 480000,
  parameter int          GAP_CYCLES   = 4800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cam_pwdn,
  output logic        cam_reset_n,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_in,
  output logic [7:0]  tbl_addr,
  input  logic [15:0] tbl_data
);
  localparam logic [31:0] RESET_M1 = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] BOOT_M1  = 32'(BOOT_CYCLES - 1);
  localparam logic [31:0] GAP_M1   = 32'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt;
  logic [15:0] tbl_q;
  logic [1:0]  byte_idx;
  logic        op_sent, abort_q, err_q;
  logic        go, rdy, nak, op_done, ack_fail;
  logic [1:0]  kind;
  logic [7:0]  byte_dat;

  assign op_done = op_sent & rdy;

`ifdef SCCB_ACK_CHECK_EN
  assign ack_fail = nak;
  assign err      = err_q;
`else
  logic unused_nak;
  assign unused_nak = nak ^ err_q;
  assign ack_fail   = 1'b0;
  assign err        = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    go       = 1'b0;
    kind     = K_BYTE;
    byte_dat = DEV_ADDR;
    case (state_q)
      S_IDLE:  if (start) state_d = S_PWR;
      S_PWR:   if (cnt == RESET_M1) state_d = S_BOOT;
      S_BOOT:  if (cnt == BOOT_M1) state_d = S_FETCH;
      S_FETCH: if (cnt == 32'd1) state_d = (tbl_data == TBL_END) ? S_FIN : S_START;
      S_START: begin
        kind = K_START;
        go   = ~op_sent & rdy;
        if (op_done) state_d = S_BYTE;
      end
      S_BYTE: begin
        case (byte_idx)
          2'd0:    byte_dat = DEV_ADDR;
          2'd1:    byte_dat = tbl_q[15:8];
          default: byte_dat = tbl_q[7:0];
        endcase
        go = ~op_sent & rdy;
        if (op_done && (ack_fail || byte_idx == 2'd2)) state_d = S_STOP;
      end
      S_STOP: begin
        kind = K_STOP;
        go   = ~op_sent & rdy;
        if (op_done) state_d = abort_q ? S_FIN : S_GAP;
      end
      S_GAP:   if (cnt == GAP_M1) state_d = (tbl_addr == 8'hFF) ? S_FIN : S_FETCH;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_q       <= 1'b0;
      cam_pwdn    <= 1'b1;
      cam_reset_n <= 1'b0;
      tbl_addr    <= '0;
      tbl_q       <= '0;
      byte_idx    <= '0;
      op_sent     <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt     <= (state_d != state_q) ? '0 : cnt + 32'd1;
      if (go) op_sent <= 1'b1;
      else if (op_done) op_sent <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          done        <= 1'b0;
          err_q       <= 1'b0;
          busy        <= 1'b1;
          tbl_addr    <= '0;
          abort_q     <= 1'b0;
          cam_pwdn    <= 1'b0;
          cam_reset_n <= 1'b0;
        end
        S_PWR:   if (state_d == S_BOOT) cam_reset_n <= 1'b1;
        S_FETCH: begin
          byte_idx <= '0;
          if (cnt == 32'd1) tbl_q <= tbl_data;
        end
        S_BYTE: if (op_done) begin
          byte_idx <= byte_idx + 2'd1;
          if (ack_fail) begin
            err_q   <= 1'b1;
            abort_q <= 1'b1;
          end
        end
        S_GAP: if (state_d == S_FETCH) tbl_addr <= tbl_addr + 8'd1;
        S_FIN: begin
          busy <= 1'b0;
          done <= ~abort_q;
        end
        default: ;
      endcase
    end
  end

  sccb_byte_tx #(
    .CLK_HZ  (CLK_HZ),
    .SCCB_HZ (SCCB_HZ)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .kind     (kind),
    .byte_dat (byte_dat),
    .sda_in   (sda_in),
    .rdy      (rdy),
    .nak      (nak),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe)
  );
endmodule

// File: tb/tb_cam_sccb_init.sv
// Bench for cam_sccb_init: table memory, SCCB bus decoder/slave, scoreboard of expected bus events.
module tb_cam_sccb_init;
  localparam int RESET_CYC = 10;
  localparam int BOOT_CYC  = 20;
  localparam int GAP_CYC   = 5;
  localparam int EV_START  = 256;
  localparam int EV_STOP   = 512;
`ifdef SCCB_ACK_CHECK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif

  logic        clk, rst, start;
  logic        busy, done, err, cam_pwdn, cam_reset_n, scl_oe, sda_oe, sda_in;
  logic [7:0]  tbl_addr;
  logic [15:0] tbl_data;
  logic [15:0] tbl [256];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  // bus decoder / slave state
  int         bitcnt = 0;
  int         dec_bytes = 0;
  int         nak_at = -1;
  logic [7:0] shreg = '0;
  bit         scl_p = 1'b1, sda_p = 1'b1, ack_drive = 1'b0;

  cam_sccb_init #(
    .CLK_HZ(400000), .SCCB_HZ(100000), .DEV_ADDR(8'h42),
    .RESET_CYCLES(RESET_CYC), .BOOT_CYCLES(BOOT_CYC), .GAP_CYCLES(GAP_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .cam_pwdn(cam_pwdn), .cam_reset_n(cam_reset_n), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .sda_in(sda_in), .tbl_addr(tbl_addr), .tbl_data(tbl_data)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  assign sda_in = ~(sda_oe | ack_drive);
  always @(posedge clk) tbl_data <= tbl[tbl_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic emit(input int ev);
    int e;
    if (exp_q.size() == 0) begin
      check("bus event (none expected)", ev, 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check("bus event", ev, e);
    end
  endtask

  // Monitor: turn SCL/SDA line activity into START/byte/STOP events; ACK unless told to NAK.
  always @(negedge clk) begin
    bit scl, sda;
    scl = ~scl_oe;
    sda = sda_in;
    if (rst) begin
      bitcnt    = 0;
      ack_drive = 1'b0;
    end else if (scl_p && scl && sda_p && !sda) begin
      emit(EV_START); bitcnt = 0;
    end else if (scl_p && scl && !sda_p && sda) begin
      emit(EV_STOP); bitcnt = 0;
    end else if (!scl_p && scl) begin
      if (bitcnt < 8) shreg = {shreg[6:0], sda};
      bitcnt++;
      if (bitcnt == 8) begin emit(int'(shreg)); dec_bytes++; end
    end else if (scl_p && !scl) begin
      if (bitcnt == 8) ack_drive = ((dec_bytes - 1) != nak_at);
      else if (bitcnt == 9) begin ack_drive = 1'b0; bitcnt = 0; end
    end
    scl_p = scl;
    sda_p = sda;
  end

  // Reference model: expected bus events and end flags straight from the table rules.
  task automatic model_push(output logic exp_done, output logic exp_err,
                            output logic [7:0] exp_addr, output int exp_scl);
    logic [7:0] b3 [3];
    int k = 0;
    exp_done = 1'b1; exp_err = 1'b0; exp_addr = '0; exp_scl = 0;
    for (int i = 0; i < 256; i++) begin
      exp_addr = 8'(i);
      if (tbl[i] == 16'hFFFF) return;
      b3[0] = 8'h42; b3[1] = tbl[i][15:8]; b3[2] = tbl[i][7:0];
      exp_q.push_back(EV_START);
      exp_scl += 1;
      for (int b = 0; b < 3; b++) begin
        exp_q.push_back(int'(b3[b]));
        exp_scl += 9;
        if (ACK_CHK && k == nak_at) begin
          exp_q.push_back(EV_STOP);
          exp_done = 1'b0; exp_err = 1'b1;
          return;
        end
        k++;
      end
      exp_q.push_back(EV_STOP);
    end
  endtask

  task automatic run_seq(input string tag, input int inj);
    logic ed, ee; logic [7:0] ea;
    int es, cyc, rlow, boot, brise, sclr;
    bit seen_bus, busy_p, scl_oe_p;
    dec_bytes = 0;
    model_push(ed, ee, ea, es);
    rlow = 0; boot = 0; brise = 0; sclr = 0; seen_bus = 0; busy_p = 0; scl_oe_p = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (cyc = 0; cyc < 50000 && busy; cyc++) begin
      if (busy && !busy_p) brise++;
      if (!cam_pwdn && !cam_reset_n) rlow++;
      if (scl_oe || sda_oe) seen_bus = 1'b1;
      if (cam_reset_n && !seen_bus) boot++;
      if (scl_oe && !scl_oe_p) sclr++;
      busy_p = busy; scl_oe_p = scl_oe;
      start = (cyc == inj);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " finished in time"}, busy, 1'b0);
    check({tag, " done"}, done, ed);
    check({tag, " err"}, err, ee);
    check({tag, " tbl_addr"}, tbl_addr, ea);
    check({tag, " runs started"}, brise, 1);
    check({tag, " reset low cycles"}, rlow, RESET_CYC);
    check({tag, " boot wait in range"}, (boot >= BOOT_CYC && boot <= BOOT_CYC + 10), 1'b1);
    check({tag, " scl pulses"}, sclr, es);
    check({tag, " events outstanding"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < 256; i++) tbl[i] = 16'hFFFF;
  endtask

  initial begin
    int cyc, n;
    rst = 1'b1; start = 1'b0;
    clear_tbl();
    repeat (3) @(negedge clk);
    check("rst cam_pwdn", cam_pwdn, 1'b1);
    check("rst cam_reset_n", cam_reset_n, 1'b0);
    check("rst scl_oe", scl_oe, 1'b0);
    check("rst sda_oe", sda_oe, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst err", err, 1'b0);
    check("rst tbl_addr", tbl_addr, 8'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    tbl[0] = 16'h1280;
    run_seq("basic", -1);

    clear_tbl();
    run_seq("empty", -1);

    tbl[0] = 16'h3A04;
    nak_at = 1;
    run_seq("nak", -1);
    nak_at = -1;

    // Abort mid-byte with reset, then restart from scratch.
    clear_tbl(); tbl[0] = 16'h1280;
    exp_q.push_back(EV_START);
    dec_bytes = 0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (cyc = 0; cyc < 2000 && !(bitcnt == 1 && scl_oe); cyc++) @(negedge clk);
    check("abort reached bit 1", bitcnt, 1);
    #2 rst = 1'b1;
    #1;
    check("abort scl_oe", scl_oe, 1'b0);
    check("abort sda_oe", sda_oe, 1'b0);
    check("abort busy", busy, 1'b0);
    @(negedge clk);
    check("abort events outstanding", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    run_seq("restart", -1);

    run_seq("start in boot", 15);

    for (int r = 0; r < 3; r++) begin
      clear_tbl();
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) tbl[i] = 16'($urandom_range(0, 16'hFFFE));
      run_seq("random", -1);
    end

    for (int i = 0; i < 256; i++) tbl[i] = 16'($urandom_range(0, 16'hFFFE));
    run_seq("full table", -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
